// File: rtl/hub75_fb_mem_mp_pkg.sv
// Shared definitions for the HUB75 multi-port framebuffer: index widths,
// reset buffer assignment and arbiter state encoding.
package hub75_fb_pkg;

    function automatic int unsigned fsel_width(input int unsigned n_frames);
        return (n_frames > 2) ? 2 : 1;
    endfunction

    localparam logic [1:0] RST_WR_BUF   = 2'd0;
    localparam logic [1:0] RST_DISP_BUF = 2'd1;
    localparam logic [1:0] RST_PEND_BUF = 2'd2;

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_OWNED = 1'b1;

endpackage

// File: rtl/hub75_fb_mem_mp_rr_arbiter.sv
// Round-robin request/grant/release arbiter; one owner at a time with at
// least one idle cycle between successive owners.
module hub75_fb_rr_arbiter
    import hub75_fb_pkg::*;
#(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned OW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] rel,
    output logic [N_PORTS-1:0] gnt,
    output logic [OW-1:0]      owner,
    output logic               owned,
    output logic               grant_c,
    output logic [OW-1:0]      pick_c
);

    logic [0:0]         state_q, state_d;
    logic [N_PORTS-1:0] gnt_q, gnt_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      rr_q, rr_d;
    logic               found_c;

    always_comb begin : next_state
        int unsigned idx;
        idx     = 0;
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        grant_c = 1'b0;
        found_c = 1'b0;
        pick_c  = '0;
        // first requester at or after the rr pointer, cyclically
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            idx = (32'(rr_q) + k) % N_PORTS;
            if (!found_c && req[OW'(idx)]) begin
                found_c = 1'b1;
                pick_c  = OW'(idx);
            end
        end
        case (state_q)
            ARB_IDLE: begin
                if (found_c) begin
                    state_d        = ARB_OWNED;
                    gnt_d          = '0;
                    gnt_d[pick_c]  = 1'b1;
                    owner_d        = pick_c;
                    rr_d           = (32'(pick_c) == N_PORTS - 1) ? '0 : pick_c + OW'(1);
                    grant_c        = 1'b1;
                end
            end
            ARB_OWNED: begin
                if (rel[owner_q]) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign owned = (state_q == ARB_OWNED);

endmodule

// File: rtl/hub75_fb_mem_mp.sv
// Multi-port, multi-buffer framebuffer: arbitrated single-port RAM with
// per-session buffer latching and single/double/triple buffer rotation.
module hub75_fb_mem_mp
    import hub75_fb_pkg::*;
#(
    parameter int unsigned       N_PORTS      = 2,
    parameter int unsigned       AW           = 12,
    parameter int unsigned       DW           = 16,
    parameter int unsigned       N_FRAMES     = 2,
    parameter logic [N_PORTS-1:0] PORT_WR_MASK = 'b01,
    localparam int unsigned      FSEL_W       = fsel_width(N_FRAMES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS-1:0]        rel,
    output logic [N_PORTS-1:0]        gnt,
    input  logic [N_PORTS*AW-1:0]     addr,
    input  logic [N_PORTS*DW-1:0]     wdata,
    input  logic [N_PORTS*(DW/4)-1:0] wmask,
    input  logic [N_PORTS-1:0]        wren,
    input  logic [N_PORTS-1:0]        rd_en,
    output logic [DW-1:0]             rdata,
    output logic                      rvalid,
    input  logic                      wr_frame_done,
    input  logic                      disp_swap,
    output logic                      wr_frame_avail,
    output logic [FSEL_W-1:0]         wr_buf,
    output logic [FSEL_W-1:0]         disp_buf,
    output logic                      err_access
);

    localparam int unsigned OW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned NIB   = DW / 4;
    localparam int unsigned MAW   = FSEL_W + AW;
    localparam int unsigned DEPTH = (1 << FSEL_W) << AW;

    logic [OW-1:0]     owner, pick_c;
    logic              owned, grant_c;
    logic [FSEL_W-1:0] wr_buf_q, wr_buf_d, disp_buf_q, disp_buf_d;
    logic [FSEL_W-1:0] pend_buf_q, pend_buf_d, sess_buf_q, sess_buf_d;
    logic              pending_q, pending_d, avail_q, avail_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d, err_q, err_d;
    logic              own_wr_c, own_rd_c, bad_c;
    logic [MAW-1:0]    mem_addr_c;
    logic [DW-1:0]     bitmask_c, wdata_c, wword_c;
    logic [DW-1:0]     mem [DEPTH];

    hub75_fb_rr_arbiter #(.N_PORTS(N_PORTS), .OW(OW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .owner   (owner),
        .owned   (owned),
        .grant_c (grant_c),
        .pick_c  (pick_c)
    );

    // owner access decode, non-owner / dual-strobe error detection
    always_comb begin : access
        bad_c      = 1'b0;
        own_wr_c   = owned & wren[owner];
        own_rd_c   = owned & rd_en[owner] & ~wren[owner];
        mem_addr_c = {sess_buf_q, addr[32'(owner)*AW +: AW]};
        wdata_c    = wdata[32'(owner)*DW +: DW];
        bitmask_c  = '0;
        for (int unsigned n = 0; n < NIB; n++) begin
            bitmask_c[n*4 +: 4] = {4{wmask[32'(owner)*NIB + n]}};
        end
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if ((wren[i] | rd_en[i]) && !(owned && owner == OW'(i))) bad_c = 1'b1;
        end
        if (own_wr_c && rd_en[owner]) bad_c = 1'b1;
        wword_c    = (mem[mem_addr_c] & ~bitmask_c) | (wdata_c & bitmask_c);
        rdata_d    = own_rd_c ? mem[mem_addr_c] : rdata_q;
        rvalid_d   = own_rd_c;
        err_d      = err_q | bad_c;
        sess_buf_d = grant_c ? (PORT_WR_MASK[pick_c] ? wr_buf_q : disp_buf_q) : sess_buf_q;
    end

    always_ff @(posedge clk) begin
        if (own_wr_c) mem[mem_addr_c] <= wword_c;
    end

    // buffer rotation on frame-done / display-swap events
    always_comb begin : buffers
        wr_buf_d   = wr_buf_q;
        disp_buf_d = disp_buf_q;
        pend_buf_d = pend_buf_q;
        pending_d  = pending_q;
        if (N_FRAMES == 2) begin
            if (disp_swap && (pending_q || wr_frame_done)) begin
                wr_buf_d   = disp_buf_q;
                disp_buf_d = wr_buf_q;
                pending_d  = 1'b0;
            end else if (wr_frame_done) begin
                pending_d = 1'b1;
            end
        end else if (N_FRAMES > 2) begin
            if (wr_frame_done && disp_swap) begin
                disp_buf_d = wr_buf_q;
                wr_buf_d   = pend_buf_q;
                pend_buf_d = disp_buf_q;
                pending_d  = 1'b0;
            end else if (wr_frame_done) begin
                wr_buf_d   = pend_buf_q;
                pend_buf_d = wr_buf_q;
                pending_d  = 1'b1;
            end else if (disp_swap && pending_q) begin
                disp_buf_d = pend_buf_q;
                pend_buf_d = disp_buf_q;
                pending_d  = 1'b0;
            end
        end
        avail_d = (N_FRAMES == 2) ? ~pending_d : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_buf_q   <= FSEL_W'(RST_WR_BUF);
            disp_buf_q <= (N_FRAMES == 1) ? '0 : FSEL_W'(RST_DISP_BUF);
            pend_buf_q <= (N_FRAMES > 2) ? FSEL_W'(RST_PEND_BUF) : '0;
            sess_buf_q <= '0;
            pending_q  <= 1'b0;
            avail_q    <= 1'b1;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_buf_q   <= wr_buf_d;
            disp_buf_q <= disp_buf_d;
            pend_buf_q <= pend_buf_d;
            sess_buf_q <= sess_buf_d;
            pending_q  <= pending_d;
            avail_q    <= avail_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
        end
    end

    assign rdata          = rdata_q;
    assign rvalid         = rvalid_q;
    assign err_access     = err_q;
    assign wr_frame_avail = avail_q;
    assign wr_buf         = wr_buf_q;
    assign disp_buf       = disp_buf_q;

endmodule
